// File: rtl/wd_servicer.sv
// rtl/wd_servicer.sv - watchdog service-side controller: heartbeat-gated service pulse with late rescue and sticky fault
module wd_servicer #(
    parameter int MISS_W = 4
) (
    input  logic              CLK,
    input  logic              WDRST,
    input  logic [7:0]        FWLEN,
    input  logic [7:0]        SRV_OFFSET,
    input  logic              ALIVE,
    input  logic              FW_OVR,
    output logic              WDSRVC,
    output logic              LATE,
    output logic              FAULT,
    output logic              CFG_ERR,
    output logic [MISS_W-1:0] MISS_CNT
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              alive_q, alive_d;
    logic              srv_q, srv_d;
    logic              late_q, late_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [7:0]        fw_last;
    logic [7:0]        off;

    assign fw_last  = FWLEN - 8'd1;
    assign off      = (SRV_OFFSET > fw_last) ? fw_last : SRV_OFFSET;
    assign CFG_ERR  = (FWLEN == 8'd0);
    assign WDSRVC   = srv_q;
    assign LATE     = late_q;
    assign FAULT    = (state_q == ST_FAULT);
    assign MISS_CNT = miss_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alive_d = alive_q | ALIVE;
        srv_d   = 1'b0;
        late_d  = 1'b0;
        miss_d  = miss_q;
        case (state_q)
            ST_RUN: begin
                if (FW_OVR) begin
                    state_d = ST_FAULT;
                end else if (CFG_ERR) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == off) begin
                    // A decision landing on a pulse cycle waits one cycle so pulses never abut
                    if (!srv_q) begin
                        if (alive_q) begin
                            srv_d   = 1'b1;
                            cnt_d   = 8'd0;
                            alive_d = ALIVE;
                        end else begin
                            state_d = ST_HOLD;
                            if (miss_q != {MISS_W{1'b1}}) begin
                                miss_d = miss_q + MISS_W'(1);
                            end
                        end
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (FW_OVR) begin
                    state_d = ST_FAULT;
                end else if (ALIVE && !CFG_ERR) begin
                    srv_d   = 1'b1;
                    late_d  = 1'b1;
                    cnt_d   = 8'd0;
                    alive_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                alive_d = alive_q;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (WDRST) begin
            state_q <= ST_RUN;
            cnt_q   <= 8'd0;
            alive_q <= 1'b0;
            srv_q   <= 1'b0;
            late_q  <= 1'b0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alive_q <= alive_d;
            srv_q   <= srv_d;
            late_q  <= late_d;
            miss_q  <= miss_d;
        end
    end

endmodule

// File: tb/tb_wd_servicer.sv
// tb/tb_wd_servicer.sv - self-checking bench for wd_servicer
module tb_wd_servicer;

    logic       clk;
    logic       wdrst;
    logic [7:0] fwlen;
    logic [7:0] srv_offset;
    logic       alive;
    logic       fw_ovr;
    logic       wdsrvc;
    logic       late;
    logic       fault;
    logic       cfg_err;
    logic [3:0] miss_cnt;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic [7:0] fl;
        logic [7:0] so;
        logic       al;
        logic       ov;
        logic       e_srv;
        logic       e_late;
        logic       e_fault;
        logic [3:0] e_miss;
    } vec_t;

    vec_t vq[$];

    wd_servicer #(.MISS_W(4)) dut (
        .CLK        (clk),
        .WDRST      (wdrst),
        .FWLEN      (fwlen),
        .SRV_OFFSET (srv_offset),
        .ALIVE      (alive),
        .FW_OVR     (fw_ovr),
        .WDSRVC     (wdsrvc),
        .LATE       (late),
        .FAULT      (fault),
        .CFG_ERR    (cfg_err),
        .MISS_CNT   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d] actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input int r, input int fl, input int so, input int al, input int ov,
                       input int es, input int el, input int ef, input int em);
        vec_t v;
        v.rst     = (r != 0);
        v.fl      = 8'(fl);
        v.so      = 8'(so);
        v.al      = (al != 0);
        v.ov      = (ov != 0);
        v.e_srv   = (es != 0);
        v.e_late  = (el != 0);
        v.e_fault = (ef != 0);
        v.e_miss  = 4'(em);
        vq.push_back(v);
    endtask

    initial begin
        int n_srv;
        int n_late;
        checks     = 0;
        errors     = 0;
        wdrst      = 1'b1;
        fwlen      = 8'd20;
        srv_offset = 8'd10;
        alive      = 1'b0;
        fw_ovr     = 1'b0;

        // Each record: inputs for cycle c, expected outputs in cycle c+1
        // happy path
        add(1, 20, 10, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 34; c++)
            add(0, 20, 10, int'(c == 3 || c == 14 || c == 25), 0, int'(c == 10 || c == 21 || c == 32), 0, 0, 0);
        // missed heartbeat, late rescue at cycle 15
        add(1, 20, 10, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 28; c++)
            add(0, 20, 10, int'(c == 15 || c == 19), 0, int'(c == 15 || c == 26), int'(c == 15), 0, int'(c >= 10));
        // starvation, then reset recovery
        add(1, 8, 4, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 13; c++)
            add(0, 8, 4, int'(c == 10 || c == 11), int'(c >= 8), 0, 0, int'(c >= 8), int'(c >= 4));
        add(1, 8, 4, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++)
            add(0, 8, 4, int'(c == 1), 0, int'(c == 4), 0, 0, 0);
        // offset clamp to FWLEN-1
        add(1, 6, 200, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 19; c++)
            add(0, 6, 200, 1, 0, int'(c == 5 || c == 11 || c == 17), 0, 0, 0);
        // ALIVE in kick-decision cycle carries to next window
        add(1, 20, 10, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 34; c++)
            add(0, 20, 10, int'(c == 3 || c == 10), 0, int'(c == 10 || c == 21), 0, 0, int'(c >= 32));
        // HOLD: ALIVE and FW_OVR together -> fault
        add(1, 20, 10, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 15; c++)
            add(0, 20, 10, int'(c >= 13), int'(c == 13), 0, 0, int'(c >= 13), int'(c >= 10));
        // WDRST on the kick-decision cycle
        add(1, 20, 10, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++)
            add(0, 20, 10, int'(c == 3), 0, 0, 0, 0, 0);
        add(1, 20, 10, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 12; c++)
            add(0, 20, 10, int'(c == 3), 0, int'(c == 10), 0, 0, 0);
        // FW_OVR while in RUN
        add(1, 20, 10, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++)
            add(0, 20, 10, 0, int'(c == 2), 0, 0, int'(c >= 2), 0);

        for (int i = 0; i < vq.size(); i++) begin
            wdrst      = vq[i].rst;
            fwlen      = vq[i].fl;
            srv_offset = vq[i].so;
            alive      = vq[i].al;
            fw_ovr     = vq[i].ov;
            tick();
            chk("wdsrvc", i, int'(wdsrvc), int'(vq[i].e_srv));
            chk("late", i, int'(late), int'(vq[i].e_late));
            chk("fault", i, int'(fault), int'(vq[i].e_fault));
            chk("miss_cnt", i, int'(miss_cnt), int'(vq[i].e_miss));
        end

        // FWLEN==0: config error, never serviced
        wdrst  = 1'b1;
        fwlen  = 8'd0;
        alive  = 1'b0;
        fw_ovr = 1'b0;
        tick();
        wdrst = 1'b0;
        chk("cfg_err_hi", 0, int'(cfg_err), 1);
        n_srv = 0;
        for (int c = 0; c < 300; c++) begin
            alive = c[0];
            tick();
            n_srv += int'(wdsrvc);
        end
        chk("cfg_no_srvc", 0, n_srv, 0);
        fwlen = 8'd20;
        #1;
        chk("cfg_err_lo", 0, int'(cfg_err), 0);

        // 20 windows each rescued late: MISS_CNT saturates
        wdrst      = 1'b1;
        fwlen      = 8'd20;
        srv_offset = 8'd10;
        alive      = 1'b0;
        tick();
        wdrst  = 1'b0;
        n_srv  = 0;
        n_late = 0;
        for (int w = 0; w < 20; w++) begin
            for (int k = 0; k < 12; k++) begin
                alive = (k == 11);
                tick();
                n_srv  += int'(wdsrvc);
                n_late += int'(late);
            end
            chk("sat_miss", w, int'(miss_cnt), (w + 1 > 15) ? 15 : w + 1);
        end
        alive = 1'b0;
        chk("sat_late_n", 0, n_late, 20);
        chk("sat_srv_n", 0, n_srv, 20);
        chk("sat_fault", 0, int'(fault), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wd_servicer.md
Name: wd_servicer

Overview:
- Service-side counterpart of the frame-window watchdog. It issues the watchdog service pulse (WDSRVC) once per frame window, but only if the application has shown liveness through the ALIVE heartbeat since the last service.
- If the heartbeat is missing, it withholds service, so the frame window overflows (FW_OVR). It then latches a fault until reset.
- It shares CLK, WDRST and FWLEN with the frame-window counter and keeps a cycle-aligned mirror of its count.

Parameters:
- MISS_W, 4, width of the saturating missed-heartbeat counter.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- WDRST  input  1  reset, synchronous, active-high. Shared with the frame-window counter.
- FWLEN  input  8  frame window length in cycles; same value as driven to the frame-window counter.
- SRV_OFFSET  input  8  cycle within the window at which service is attempted.
- ALIVE  input  1  application heartbeat; single-cycle or level, sampled each cycle.
- FW_OVR  input  1  overflow flag from the frame-window counter.
- WDSRVC  output  1  service pulse to the frame-window counter; exactly one cycle wide.
- LATE  output  1  one-cycle pulse, coincident with a late WDSRVC.
- FAULT  output  1  sticky watchdog fault.
- CFG_ERR  output  1  high while FWLEN==0.
- MISS_CNT  output  MISS_W  saturating count of missed on-time services.

Behaviour:
- Reset (WDRST=1 at a CLK edge):
  - Outputs: WDSRVC=0, LATE=0, FAULT=0, MISS_CNT=0.
  - Internal: cnt=0, alive_flag=0, state=RUN.
  - WDRST has priority over every other event, in every state.
- Effective offset:
  - off = min(SRV_OFFSET, FWLEN-1), computed in 8 bits.
  - FWLEN==0: CFG_ERR=1, state is forced to HOLD, cnt frozen, no WDSRVC ever issued.
  - CFG_ERR is combinational from FWLEN.
- alive_flag:
  - Set by ALIVE=1 in any cycle not consumed by a kick.
  - ALIVE=1 in the same cycle as an on-time kick sets alive_flag for the next window; it is not lost.
- State RUN:
  - cnt increments by 1 each cycle.
  - When cnt==off and alive_flag=1: WDSRVC=1 in the next cycle (registered), cnt<=0, alive_flag<=0, stay in RUN.
  - After the kick, cnt is aligned so that the frame-window counter's 0 matches cnt 0 (its count clears on WDSRVC).
  - When cnt==off and alive_flag=0: MISS_CNT increments (saturating at 2^MISS_W-1), state<=HOLD, cnt stops.
- State HOLD:
  - No kicks.
  - ALIVE=1 with FW_OVR=0: late kick. WDSRVC=1 and LATE=1 in the next cycle, cnt<=0, alive_flag<=0, state<=RUN.
  - FW_OVR=1, including when it coincides with ALIVE: state<=FAULT, FAULT<=1. Overflow wins over a late heartbeat.
- State FAULT:
  - FAULT held at 1, WDSRVC held at 0, ALIVE ignored, MISS_CNT frozen.
  - Left only via WDRST.
- Output timing:
  - WDSRVC and LATE are registered.
  - Latency is one cycle from the decision edge to the pulse.
  - They are never high for two consecutive cycles.
- FWLEN/SRV_OFFSET changes:
  - Take effect on the next comparison.
  - If cnt is already past the new off, no wrap: cnt continues to 255, then saturates at 255 (no kick) until FW_OVR drives FAULT.
- FW_OVR seen while in RUN (misconfiguration, window shorter than off):
  - state<=FAULT, FAULT<=1.

Test Plan:
- Happy path. FWLEN=20, SRV_OFFSET=10, ALIVE pulsed at cycle 3 of each window.
  - WDSRVC pulses at cycles 11, 22, 33 after reset release.
  - FW_OVR never rises; MISS_CNT=0, FAULT=0.
- Missed heartbeat, late rescue. FWLEN=20, SRV_OFFSET=10, no ALIVE in window 1, ALIVE at cycle 15.
  - MISS_CNT=1; WDSRVC and LATE both high at cycle 16.
  - FW_OVR stays 0; RUN resumes and the next kick falls 11 cycles later.
- Starvation. FWLEN=8, SRV_OFFSET=4, ALIVE never asserted.
  - No WDSRVC; FW_OVR rises at cycle 8, FAULT=1 the next cycle.
  - ALIVE pulses afterwards produce no WDSRVC; WDRST clears FAULT, MISS_CNT, and returns to RUN.
- Clamp and config error.
  - FWLEN=6, SRV_OFFSET=200, ALIVE held high: kicks at off=5, every 6 cycles; FW_OVR never rises.
  - FWLEN=0: CFG_ERR=1, no WDSRVC for 300 cycles.
- Simultaneous events.
  - ALIVE in the kick-decision cycle: the next window kicks with no further ALIVE.
  - In HOLD, ALIVE and FW_OVR in the same cycle: FAULT=1, no WDSRVC.
  - WDRST coincident with a kick decision: no WDSRVC, all outputs at reset values.
- Saturation. MISS_W=4, 20 windows each recovered late.
  - MISS_CNT reaches 15 and stays at 15; LATE pulses 20 times.
